// File: rtl/muvi_line_engine.sv
// muvi_line_engine
//   Bresenham line rasteriser. A go pulse while idle latches the two
//   endpoints and the colour. The block then walks the line one point per
//   clock and emits a pixel write strobe for every point that lies inside
//   the visible H_RES x V_RES window. Points outside the window still take
//   their cycle but are not written. A single-cycle done pulse marks the
//   end of each line.
//
// Ports
//   clock       in   single clock, rising edge
//   reset       in   synchronous reset, active low
//   go          in   start request, sampled only while idle and not in the done cycle
//   stax, stay  in   8-bit line start x / y
//   endx, endy  in   8-bit line end x / y
//   colour_in   in   3-bit line colour, latched together with the coordinates
//   busy        out  high while a line is being drawn
//   wr          out  pixel write strobe
//   addr        out  pixel address {y, x}, valid while wr=1
//   colour_out  out  colour of the current line (held until the next accepted go)
//   done        out  one-cycle pulse in the cycle after the last point
module muvi_line_engine #(
   parameter int H_RES = 160,
   parameter int V_RES = 120
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        go,
   input  logic [7:0]  stax,
   input  logic [7:0]  stay,
   input  logic [7:0]  endx,
   input  logic [7:0]  endy,
   input  logic [2:0]  colour_in,
   output logic        busy,
   output logic        wr,
   output logic [15:0] addr,
   output logic [2:0]  colour_out,
   output logic        done
);

   // 9-bit limits so that a window as large as 256 x 256 can still be expressed.
   localparam logic [8:0] H_LIM = 9'(H_RES);
   localparam logic [8:0] V_LIM = 9'(V_RES);

   typedef enum logic {IDLE, DRAW} state_t;

   state_t             state_reg,      state_next;
   logic [7:0]         x_reg,          x_next;
   logic [7:0]         y_reg,          y_next;
   logic [7:0]         endx_reg,       endx_next;
   logic [7:0]         endy_reg,       endy_next;
   logic signed [10:0] dx_reg,         dx_next;
   logic signed [10:0] dy_reg,         dy_next;
   logic signed [10:0] err_reg,        err_next;
   logic               step_x_neg_reg, step_x_neg_next;
   logic               step_y_neg_reg, step_y_neg_next;
   logic               busy_reg,       busy_next;
   logic               wr_reg,         wr_next;
   logic [15:0]        addr_reg,       addr_next;
   logic [2:0]         colour_reg,     colour_next;
   logic               done_reg,       done_next;

   function automatic logic in_view(input logic [7:0] px, input logic [7:0] py);
      return ({1'b0, px} < H_LIM) && ({1'b0, py} < V_LIM);
   endfunction

   // Set-up terms computed straight from the input ports. They are only
   // used at the accepting edge.
   logic [7:0]         go_dx_mag;
   logic [7:0]         go_dy_mag;
   logic signed [10:0] go_dx;
   logic signed [10:0] go_dy;
   logic signed [10:0] go_err;

   assign go_dx_mag = (endx >= stax) ? (endx - stax) : (stax - endx);
   assign go_dy_mag = (endy >= stay) ? (endy - stay) : (stay - endy);
   assign go_dx     = $signed({3'b000, go_dx_mag});
   assign go_dy     = 11'sd0 - $signed({3'b000, go_dy_mag});
   assign go_err    = go_dx + go_dy;

   // Bresenham step terms. |err| stays within +/-510, so doubling it
   // always fits in 11 signed bits.
   logic signed [10:0] e2;
   logic               step_x_ok;
   logic               step_y_ok;
   logic signed [10:0] err_step;
   logic [7:0]         x_step;
   logic [7:0]         y_step;
   logic               at_end;

   assign e2        = $signed({err_reg[9:0], 1'b0});
   assign step_x_ok = (e2 >= dy_reg);
   assign step_y_ok = (e2 <= dx_reg);
   assign err_step  = err_reg + (step_x_ok ? dy_reg : 11'sd0) + (step_y_ok ? dx_reg : 11'sd0);
   assign x_step    = step_x_ok ? (step_x_neg_reg ? x_reg - 8'd1 : x_reg + 8'd1) : x_reg;
   assign y_step    = step_y_ok ? (step_y_neg_reg ? y_reg - 8'd1 : y_reg + 8'd1) : y_reg;
   assign at_end    = (x_reg == endx_reg) && (y_reg == endy_reg);

   always_comb begin
      state_next      = state_reg;
      x_next          = x_reg;
      y_next          = y_reg;
      endx_next       = endx_reg;
      endy_next       = endy_reg;
      dx_next         = dx_reg;
      dy_next         = dy_reg;
      err_next        = err_reg;
      step_x_neg_next = step_x_neg_reg;
      step_y_neg_next = step_y_neg_reg;
      busy_next       = busy_reg;
      wr_next         = 1'b0;
      addr_next       = addr_reg;
      colour_next     = colour_reg;
      done_next       = 1'b0;

      case (state_reg)
         IDLE: begin
            busy_next = 1'b0;
            // done_reg blocks acceptance in the done cycle, which leaves
            // at least one idle cycle between two lines.
            if (go && !done_reg) begin
               state_next      = DRAW;
               busy_next       = 1'b1;
               x_next          = stax;
               y_next          = stay;
               endx_next       = endx;
               endy_next       = endy;
               dx_next         = go_dx;
               dy_next         = go_dy;
               err_next        = go_err;
               step_x_neg_next = (endx < stax);
               step_y_neg_next = (endy < stay);
               colour_next     = colour_in;
               addr_next       = {stay, stax};
               wr_next         = in_view(stax, stay);
            end
         end
         DRAW: begin
            if (at_end) begin
               state_next = IDLE;
               busy_next  = 1'b0;
               done_next  = 1'b1;
            end else begin
               busy_next = 1'b1;
               x_next    = x_step;
               y_next    = y_step;
               err_next  = err_step;
               addr_next = {y_step, x_step};
               wr_next   = in_view(x_step, y_step);
            end
         end
         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg      <= IDLE;
         x_reg          <= 8'd0;
         y_reg          <= 8'd0;
         endx_reg       <= 8'd0;
         endy_reg       <= 8'd0;
         dx_reg         <= 11'sd0;
         dy_reg         <= 11'sd0;
         err_reg        <= 11'sd0;
         step_x_neg_reg <= 1'b0;
         step_y_neg_reg <= 1'b0;
         busy_reg       <= 1'b0;
         wr_reg         <= 1'b0;
         addr_reg       <= 16'h0000;
         colour_reg     <= 3'b000;
         done_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         x_reg          <= x_next;
         y_reg          <= y_next;
         endx_reg       <= endx_next;
         endy_reg       <= endy_next;
         dx_reg         <= dx_next;
         dy_reg         <= dy_next;
         err_reg        <= err_next;
         step_x_neg_reg <= step_x_neg_next;
         step_y_neg_reg <= step_y_neg_next;
         busy_reg       <= busy_next;
         wr_reg         <= wr_next;
         addr_reg       <= addr_next;
         colour_reg     <= colour_next;
         done_reg       <= done_next;
      end
   end

   assign busy       = busy_reg;
   assign wr         = wr_reg;
   assign addr       = addr_reg;
   assign colour_out = colour_reg;
   assign done       = done_reg;

endmodule

// File: doc/muvi_line_engine.md
MUVI_LINE_ENGINE -- requirements
Module: muvi_line_engine

Interface
REQ-001 Parameter H_RES, default 160, SHALL set the visible width in pixels; columns 0..H_RES-1 are visible.
REQ-002 Parameter V_RES, default 120, SHALL set the visible height in pixels; rows 0..V_RES-1 are visible.
REQ-003 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 go  input  1  SHALL request a line draw; sampled only while idle.
REQ-006 stax, stay  input  8 each  SHALL carry the line start x and y (unsigned).
REQ-007 endx, endy  input  8 each  SHALL carry the line end x and y (unsigned).
REQ-008 colour_in  input  3  SHALL carry the line colour; latched with the coordinates.
REQ-009 busy  output  1  SHALL be high while a line is in progress.
REQ-010 wr  output  1  SHALL be a pixel write strobe, one pixel per cycle.
REQ-011 addr  output  16  SHALL be the pixel address {y[15:8], x[7:0]}, valid when wr=1.
REQ-012 colour_out  output  3  SHALL be the latched colour for the current line.
REQ-013 done  output  1  SHALL pulse high for one cycle when a line completes.

Function
REQ-014 The block SHALL use two states: IDLE and DRAW; all outputs SHALL be registered.
REQ-015 In IDLE with go=1 at edge T, the block SHALL latch stax/stay/endx/endy/colour_in and enter DRAW, with busy=1 from cycle T+1.
REQ-016 On entry, the block SHALL compute dx=|endx-stax|, dy=-|endy-stay|, step_x=+1 if endx>=stax else -1, step_y=+1 if endy>=stay else -1, and err=dx+dy.
REQ-017 err and e2=2*err SHALL be held in an 11-bit signed format; no overflow is permitted for any 8-bit endpoints.
REQ-018 In each DRAW cycle the block SHALL present the current point (x,y) on addr, starting with (stax,stay) in cycle T+1.
REQ-019 In each DRAW cycle, wr SHALL be 1 if x<H_RES and y<V_RES, else 0; the cycle is still consumed.
REQ-020 If the current point equals (endx,endy), the next state SHALL be IDLE; otherwise the Bresenham step applies.
REQ-021 Bresenham step: if e2>=dy then err+=dy and x+=step_x; if e2<=dx then err+=dx and y+=step_y; both updates SHALL apply in the same cycle when both conditions hold.
REQ-022 A line SHALL occupy exactly max(dx,|dy|)+1 DRAW cycles, one per point, with no gaps.
REQ-023 In the cycle after the last point, the block SHALL drive busy=0, wr=0 and done=1; done SHALL return to 0 after one cycle.
REQ-024 go SHALL be ignored while busy=1 or during the done cycle; in the done cycle the latched endpoints SHALL be unaffected.
REQ-025 A new go SHALL be accepted in the cycle after done (or later), giving a minimum line-to-line gap of one idle cycle.
REQ-026 Input coordinates SHALL be don't-care except at the accepting edge.
REQ-027 colour_out SHALL be updated only at acceptance and SHALL hold until the next acceptance.
REQ-028 A degenerate line (start==end) SHALL produce exactly one DRAW cycle.

Reset
REQ-029 When reset=0 at an edge, the block SHALL enter IDLE and drive busy=0, wr=0, done=0, addr=16'h0000 and colour_out=3'b000.
REQ-030 Reset SHALL override any in-progress line, which is abandoned with no further wr and no done pulse.
REQ-031 Reset SHALL override a simultaneous go.
REQ-032 After reset is released, the first go SHALL be accepted normally.

Verification
REQ-033 Horizontal line: go with (110,60)->(120,60), colour 3'b101 -> 11 wr cycles, addr x=110..120 with y=60, colour_out=5, done one cycle after the x=120 write.
REQ-034 Vertical line: go with (80,90)->(80,100) -> 11 wr cycles, y=90..100 with x=80, busy high exactly 11 cycles.
REQ-035 Reverse shallow line: go with (117,75)->(108,71) -> 10 wr cycles, x decrements by 1 every cycle, y decrements 4 times in total, first addr {75,117}, last addr {71,108}.
REQ-036 Clipping: go with (150,60)->(170,60) -> busy for 21 cycles, wr=1 only for x=150..159, done after x=170.
REQ-037 Protocol: go with (80,60)->(80,60) -> exactly 1 wr cycle at {60,80}; a second go pulsed while busy of a long line -> ignored, no extra writes.
REQ-038 Reset mid-line: reset=0 on the 5th DRAW cycle of (50,60)->(40,60) -> next cycle busy=0, wr=0, done never asserted.
